// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings and helpers for the data memory arbiter.
// Imported by the arbiter top and its grant sub-module.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    ID_CPU = 1'b0,
    ID_DMA = 1'b1
  } port_id_e;

  localparam int unsigned PRIORITY_RR    = 0;
  localparam int unsigned PRIORITY_FIXED = 1;

  typedef struct packed {
    port_id_e    id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xact_t;

  // True when any byte-address bit at or above valid_bits is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input int unsigned valid_bits);
    logic [31:0] mask;
    mask = (valid_bits >= 32) ? 32'd0 : ~((32'd1 << valid_bits) - 32'd1);
    return |(addr & mask);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way grant logic: round-robin on last_grant, or fixed CPU priority.
// last_grant resets to DMA so the CPU wins the first tie.
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     fixed_prio,
  input  logic     en,
  input  logic     req_cpu,
  input  logic     req_dma,
  output logic     gnt_valid,
  output port_id_e gnt_id
);

  port_id_e last_q;

  always_comb begin
    gnt_valid = en & (req_cpu | req_dma);
    gnt_id    = ID_CPU;
    if (req_cpu && req_dma) begin
      gnt_id = (fixed_prio || (last_q == ID_DMA)) ? ID_CPU : ID_DMA;
    end else if (req_dma) begin
      gnt_id = ID_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ID_DMA;
    end else if (gnt_valid) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU and DMA access to a single-port data memory and sequences
// each transaction as IDLE -> ACCESS -> RESP, with a registered ack pulse after RESP.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = PRIORITY_RR,
  parameter int unsigned MEM_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e   state_q;
  xact_t    cur_q;
  xact_t    sel;
  logic     err_q;
  logic     fixed_prio;
  logic     arb_en;
  logic     gnt_valid;
  port_id_e gnt_id;

  assign fixed_prio = (PRIORITY_MODE == PRIORITY_FIXED);
  assign arb_en     = (state_q == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .fixed_prio(fixed_prio),
    .en        (arb_en),
    .req_cpu   (cpu_req),
    .req_dma   (dma_req),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    if (gnt_id == ID_CPU) begin
      sel = '{id: ID_CPU, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    end else begin
      sel = '{id: ID_DMA, we: dma_we, addr: dma_addr, wdata: dma_wdata};
    end
  end

  // cur_q.addr/wdata only load on in-range grants, so the memory bus holds its
  // last real access outside ACCESS.
  assign mem_addr  = cur_q.addr;
  assign mem_wdata = cur_q.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      err_q     <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      dma_ack   <= 1'b0;
      dma_err   <= 1'b0;
      dma_rdata <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            cur_q.id <= sel.id;
            cur_q.we <= sel.we;
            if (addr_out_of_range(sel.addr, MEM_ADDR_BITS)) begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              err_q       <= 1'b0;
              cur_q.addr  <= sel.addr;
              cur_q.wdata <= sel.wdata;
              mem_write   <= sel.we;
              mem_read    <= ~sel.we;
              state_q     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!cur_q.we) begin
            if (cur_q.id == ID_CPU) begin
              cpu_rdata <= mem_rdata;
            end else begin
              dma_rdata <= mem_rdata;
            end
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (cur_q.id == ID_CPU) begin
            cpu_ack <= 1'b1;
            cpu_err <= err_q;
            if (err_q) cpu_rdata <= '0;
          end else begin
            dma_ack <= 1'b1;
            dma_err <= err_q;
            if (err_q) dma_rdata <= '0;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
